ram_bus_arbiter: RTL and testbench

- Arbitrates the single 2 KB static RAM (11-bit address, 8-bit data, active-low WB/GB/EB strobes) between two requesters: port 0 (CPU) and port 1 (DMA/display).
- Sequences each access as a registered SETUP/STROBE/HOLD cycle, so the RAM's level-sensitive write never sees address or data change while WB is low.
- Sits between the requesters and the RAM chip model; the board-level tri-state join is external.

---
 rtl/nic8_ram_pkg.sv | 30 +++
 rtl/ram_arb_pick.sv | 36 +++
 rtl/ram_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nic8_ram_pkg.sv
// Shared types and constants for the 2 KB static RAM bus arbiter.
package nic8_ram_pkg;

  localparam int RAM_AW    = 11;
  localparam int RAM_DW    = 8;
  localparam int NUM_PORTS = 2;
  localparam int PORT_IW   = $clog2(NUM_PORTS);

  // Index of a requester port (0 = CPU, 1 = DMA/display).
  typedef logic [PORT_IW-1:0] port_idx_t;

  // Access sequencer states; every access walks SETUP -> STROBE -> HOLD.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  // Convert a one-hot port vector to its index (zero when no bit is set).
  function automatic port_idx_t onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner picker for the RAM bus arbiter.
// RAM_ARB_ROUND_ROBIN_EN defined: on a tie the port that did not win last
// time is chosen. Undefined: port 0 always wins ties.
module ram_arb_pick
  import nic8_ram_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  port_idx_t            last_winner,
`endif
  output logic [NUM_PORTS-1:0] winner
);

  // Pick exactly one requesting port, or none when nobody asks.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely
    // combinational; a path that leaves winner unassigned would infer a latch.
    winner = '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (req[0] && req[1]) begin
      winner = (last_winner == 1'b0) ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      winner = 2'b01;
    end else if (req[1]) begin
      winner = 2'b10;
    end
`else
    if (req[0]) begin
      winner = 2'b01;
    end else if (req[1]) begin
      winner = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-port arbiter for a single 2 KB static RAM. Each access is sequenced
// as registered SETUP / STROBE / HOLD so address and data never move while
// the level-sensitive write strobe is low. All RAM controls come straight
// from flops. Optional macro: RAM_ARB_ROUND_ROBIN_EN (alternate on ties).
module ram_bus_arbiter
  import nic8_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 CLK1,
  input  logic                 CLRB1,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [RAM_AW-1:0]    addr0,
  input  logic [RAM_AW-1:0]    addr1,
  input  logic [RAM_DW-1:0]    wdata0,
  input  logic [RAM_DW-1:0]    wdata1,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [NUM_PORTS-1:0] done,
  output logic [RAM_DW-1:0]    rdata,
  output logic [RAM_AW-1:0]    ram_a,
  output logic                 ram_eb,
  output logic                 ram_gb,
  output logic                 ram_wb,
  output logic [RAM_DW-1:0]    ram_dq_out,
  output logic                 ram_dq_oe,
  input  logic [RAM_DW-1:0]    ram_dq_in
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("ram_bus_arbiter: WAIT_CYCLES must be in 1..15");
  end

  // Counter reload: STROBE lasts until the counter reaches zero.
  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic [RAM_DW-1:0]      rdata_q, rdata_d;
  logic [RAM_AW-1:0]      ram_a_q, ram_a_d;
  logic [RAM_DW-1:0]      dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   eb_q, eb_d;
  logic                   gb_q, gb_d;
  logic                   wb_q, wb_d;
  logic                   we_q, we_d;
  port_idx_t              win_q, win_d;

  logic [NUM_PORTS-1:0]   pick_oh;
  port_idx_t              pick_idx;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  port_idx_t              last_q, last_d;
`endif

  ram_arb_pick u_pick (
    .req         (req),
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .last_winner (last_q),
`endif
    .winner      (pick_oh)
  );

  assign pick_idx = onehot_to_idx(pick_oh);

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    ram_a_d  = ram_a_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    eb_d     = eb_q;
    gb_d     = gb_q;
    wb_d     = wb_q;
    we_d     = we_q;
    win_d    = win_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    case (state_q)
      IDLE: begin
        eb_d    = 1'b1;
        gb_d    = 1'b1;
        wb_d    = 1'b1;
        dq_oe_d = 1'b0;
        gnt_d   = '0;
        if (|req) begin
          // Capture the winner's command; later input changes are ignored.
          win_d    = pick_idx;
          gnt_d    = pick_oh;
          we_d     = we[pick_idx];
          ram_a_d  = (pick_idx == 1'b1) ? addr1 : addr0;
          dq_out_d = (pick_idx == 1'b1) ? wdata1 : wdata0;
          dq_oe_d  = we[pick_idx];
          eb_d     = 1'b0;
          state_d  = SETUP;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d   = pick_idx;
`endif
        end
      end

      SETUP: begin
        cnt_d   = CNT_RELOAD;
        state_d = STROBE;
        if (we_q) begin
          wb_d = 1'b0;
        end else begin
          gb_d = 1'b0;
        end
      end

      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d       = HOLD;
          wb_d          = 1'b1;
          gb_d          = 1'b1;
          done_d[win_q] = 1'b1;
          if (!we_q) begin
            rdata_d = ram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        // Address and data stay put for hold time; release the bus on exit.
        state_d = IDLE;
        gnt_d   = '0;
        eb_d    = 1'b1;
        dq_oe_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and RAM-control registers; strobes rise at once on reset.
  always_ff @(posedge CLK1 or negedge CLRB1) begin
    if (!CLRB1) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      ram_a_q  <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      eb_q     <= 1'b1;
      gb_q     <= 1'b1;
      wb_q     <= 1'b1;
      we_q     <= 1'b0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      ram_a_q  <= ram_a_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      eb_q     <= eb_d;
      gb_q     <= gb_d;
      wb_q     <= wb_d;
      we_q     <= we_d;
      win_q    <= win_d;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Last-winner flop; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge CLK1 or negedge CLRB1) begin
    if (!CLRB1) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign ram_a      = ram_a_q;
  assign ram_eb     = eb_q;
  assign ram_gb     = gb_q;
  assign ram_wb     = wb_q;
  assign ram_dq_out = dq_out_q;
  assign ram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: one instance with WAIT_CYCLES=1 and
// one with WAIT_CYCLES=4, each attached to a small behavioural RAM.
module tb_ram_bus_arbiter;

  typedef struct packed {
    logic [1:0] done;
    logic [7:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]  req_v   [2];
  logic [1:0]  we_v    [2];
  logic [10:0] a0_v    [2];
  logic [10:0] a1_v    [2];
  logic [7:0]  wd0_v   [2];
  logic [7:0]  wd1_v   [2];
  logic [1:0]  gnt_v   [2];
  logic [1:0]  done_v  [2];
  logic [7:0]  rdata_v [2];
  logic [10:0] ra_v    [2];
  logic [7:0]  dqo_v   [2];
  logic        eb_v    [2];
  logic        gb_v    [2];
  logic        wb_v    [2];
  logic        oe_v    [2];
  logic [7:0]  dqi_w1, dqi_w4;

  logic [7:0]  mem_w1 [2048];
  logic [7:0]  mem_w4 [2048];

  exp_t        sb_w1 [$];
  exp_t        sb_w4 [$];
  logic [7:0]  rd_model [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .CLK1(clk), .CLRB1(rst_n), .req(req_v[0]), .we(we_v[0]),
    .addr0(a0_v[0]), .addr1(a1_v[0]), .wdata0(wd0_v[0]), .wdata1(wd1_v[0]),
    .gnt(gnt_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .ram_a(ra_v[0]),
    .ram_eb(eb_v[0]), .ram_gb(gb_v[0]), .ram_wb(wb_v[0]),
    .ram_dq_out(dqo_v[0]), .ram_dq_oe(oe_v[0]), .ram_dq_in(dqi_w1)
  );

  ram_bus_arbiter #(.WAIT_CYCLES(4)) u_dut_w4 (
    .CLK1(clk), .CLRB1(rst_n), .req(req_v[1]), .we(we_v[1]),
    .addr0(a0_v[1]), .addr1(a1_v[1]), .wdata0(wd0_v[1]), .wdata1(wd1_v[1]),
    .gnt(gnt_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .ram_a(ra_v[1]),
    .ram_eb(eb_v[1]), .ram_gb(gb_v[1]), .ram_wb(wb_v[1]),
    .ram_dq_out(dqo_v[1]), .ram_dq_oe(oe_v[1]), .ram_dq_in(dqi_w4)
  );

  // Behavioural RAMs: write when enabled and write-strobed at a clock edge.
  always @(posedge clk) begin
    if (!eb_v[0] && !wb_v[0]) mem_w1[ra_v[0]] <= dqo_v[0];
  end
  always @(posedge clk) begin
    if (!eb_v[1] && !wb_v[1]) mem_w4[ra_v[1]] <= dqo_v[1];
  end
  assign dqi_w1 = (!eb_v[0] && !gb_v[0]) ? mem_w1[ra_v[0]] : 8'hEE;
  assign dqi_w4 = (!eb_v[1] && !gb_v[1]) ? mem_w4[ra_v[1]] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int u, input exp_t e);
    if (u == 0) sb_w1.push_back(e);
    else        sb_w4.push_back(e);
  endtask

  // Pop the oldest expected completion for instance u and compare.
  task automatic score(input int u, input logic [1:0] d, input logic [7:0] rd);
    exp_t e;
    int   n;
    n = (u == 0) ? sb_w1.size() : sb_w4.size();
    if (n == 0) begin
      check($sformatf("unexpected_done_u%0d", u), 32'(d), 32'd0);
    end else begin
      if (u == 0) e = sb_w1.pop_front();
      else        e = sb_w4.pop_front();
      check($sformatf("done_port_u%0d", u), 32'(d), 32'(e.done));
      check($sformatf("rdata_u%0d", u), 32'(rd), 32'(e.rdata));
    end
  endtask

  // Monitor: any done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (done_v[0] != 2'b00) score(0, done_v[0], rdata_v[0]);
    if (done_v[1] != 2'b00) score(1, done_v[1], rdata_v[1]);
  end

  // One complete access on instance u from port p; checks the bus timing.
  // disturb: after grant, drop req and scramble the port's command inputs.
  task automatic txn(input int u, input int p, input logic w, input logic [10:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input logic disturb);
    int   wc;
    int   t, cyc, wb_low, gb_low, bad_bus, bad_oe;
    exp_t e;
    wc = (u == 0) ? 1 : 4;
    req_v[u][p] = 1'b1;
    we_v[u][p]  = w;
    if (p == 0) begin a0_v[u] = a; wd0_v[u] = d; end
    else        begin a1_v[u] = a; wd1_v[u] = d; end
    e.done  = (p == 0) ? 2'b01 : 2'b10;
    e.rdata = w ? rd_model[u] : exp_rd;
    if (!w) rd_model[u] = exp_rd;
    push(u, e);

    t = 0;
    do begin @(posedge clk); #1; t++; end while (gnt_v[u] == 2'b00 && t < 20);
    check("grant", 32'(gnt_v[u]), 32'(e.done));
    if (disturb) begin
      req_v[u][p] = 1'b0;
      we_v[u][p]  = ~w;
      if (p == 0) begin a0_v[u] = 11'h7FF; wd0_v[u] = ~d; end
      else        begin a1_v[u] = 11'h7FF; wd1_v[u] = ~d; end
    end

    cyc = 0; wb_low = 0; gb_low = 0; bad_bus = 0; bad_oe = 0;
    while (done_v[u] == 2'b00 && cyc < 40) begin
      if (ra_v[u] !== a || eb_v[u] !== 1'b0) bad_bus++;
      if (w && dqo_v[u] !== d) bad_bus++;
      if (oe_v[u] !== w) bad_oe++;
      if (wb_v[u] === 1'b0) wb_low++;
      if (gb_v[u] === 1'b0) gb_low++;
      @(posedge clk); #1;
      cyc++;
    end
    // Done is raised WAIT_CYCLES+1 edges after the grant edge.
    check("done_latency", 32'(cyc), 32'(wc + 1));
    check("wb_low_cycles", 32'(wb_low), w ? 32'(wc) : 32'd0);
    check("gb_low_cycles", 32'(gb_low), w ? 32'd0 : 32'(wc));
    check("bus_stable", 32'(bad_bus), 32'd0);
    if (oe_v[u] !== w) bad_oe++;
    check("dq_oe", 32'(bad_oe), 32'd0);
    check("hold_strobes", 32'({eb_v[u], gb_v[u], wb_v[u]}), 32'b011);
    check("hold_addr", 32'(ra_v[u]), 32'(a));
    req_v[u][p] = 1'b0;
    @(posedge clk); #1;
    check("idle_after", 32'({gnt_v[u], eb_v[u], gb_v[u], wb_v[u], oe_v[u]}), 32'b001110);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, ndone, prev;
    exp_t e;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req_v[u] = '0; we_v[u] = '0; a0_v[u] = '0; a1_v[u] = '0;
      wd0_v[u] = '0; wd1_v[u] = '0; rd_model[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_ctrl", 32'({gnt_v[u], done_v[u], rdata_v[u], oe_v[u], eb_v[u], gb_v[u], wb_v[u]}),
            32'h0007);
      check("reset_bus", 32'({ra_v[u], dqo_v[u]}), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // WAIT_CYCLES = 1: write, read back, boundary address, req drop.
    txn(0, 0, 1'b1, 11'h123, 8'h5A, 8'h00, 1'b0);
    txn(0, 1, 1'b0, 11'h123, 8'h00, 8'h5A, 1'b0);
    txn(0, 1, 1'b1, 11'h7FF, 8'hA5, 8'h00, 1'b0);
    txn(0, 0, 1'b0, 11'h7FF, 8'h00, 8'hA5, 1'b0);
    txn(0, 0, 1'b1, 11'h000, 8'h3C, 8'h00, 1'b1);
    txn(0, 1, 1'b0, 11'h000, 8'h00, 8'h3C, 1'b0);

    // Contention: both ports request continuously for four accesses.
    we_v[0] = 2'b11; a0_v[0] = 11'h010; a1_v[0] = 11'h020;
    wd0_v[0] = 8'h11; wd1_v[0] = 8'h22;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      e.done = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      e.done = 2'b01;
`endif
      e.rdata = rd_model[0];
      push(0, e);
    end
    req_v[0] = 2'b11;
    ndone = 0; prev = 0;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      @(posedge clk); #1;
      if (done_v[0] != 2'b00) begin
        if (ndone > 0) check("contention_spacing", 32'(c - prev), 32'd4);
        prev = c;
        ndone++;
        if (ndone == 4) req_v[0] = 2'b00;
      end
    end
    check("contention_count", 32'(ndone), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check("contention_idle", 32'(gnt_v[0]), 32'd0);

    // Reset during the write strobe: strobes rise without a clock edge.
    req_v[0] = 2'b01; we_v[0] = 2'b01; a0_v[0] = 11'h000; wd0_v[0] = 8'h99;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (wb_v[0] !== 1'b0 && t < 20);
    check("abort_wb_low", 32'(wb_v[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({eb_v[0], gb_v[0], wb_v[0], oe_v[0]}), 32'b1110);
    check("abort_gnt", 32'(gnt_v[0]), 32'd0);
    req_v[0] = 2'b00;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // The aborted write must not have reached the RAM.
    txn(0, 1, 1'b0, 11'h000, 8'h00, 8'h3C, 1'b0);

    // WAIT_CYCLES = 4: stretched strobes; addr0 moves to 0x7FF mid-read.
    txn(1, 1, 1'b1, 11'h045, 8'hC3, 8'h00, 1'b0);
    txn(1, 0, 1'b0, 11'h045, 8'h00, 8'hC3, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_w1_empty", 32'(sb_w1.size()), 32'd0);
    check("scoreboard_w4_empty", 32'(sb_w4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
